// File: rtl/mmio_gen_pkg.sv
// Shared bus widths and error-cause encoding for the MMIO slot controller.
package mmio_gen_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 21;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_RDWR,
        ERR_UNMAPPED,
        ERR_RANGE
    } err_cause_e;
endpackage

// File: rtl/mmio_err_log.sv
// Sticky bus-error log: flag, saturating count and first faulting address.
module mmio_err_log
    import mmio_gen_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              err_clr_i,
    input  logic              err_evt_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              err_flag_o,
    output logic [7:0]        err_cnt_o,
    output logic [ADDR_W-1:0] err_addr_o
);
    logic              flag_q, flag_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    // A clear coinciding with an error restarts the log with that error.
    always_comb begin
        flag_d = flag_q;
        cnt_d  = cnt_q;
        addr_d = addr_q;
        if (err_clr_i) begin
            flag_d = err_evt_i;
            cnt_d  = err_evt_i ? 8'd1 : 8'd0;
            addr_d = err_evt_i ? addr_i : '0;
        end else if (err_evt_i) begin
            flag_d = 1'b1;
            if (cnt_q != 8'hFF) begin
                cnt_d = cnt_q + 8'd1;
            end
            if (!flag_q) begin
                addr_d = addr_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flag_q <= 1'b0;
            cnt_q  <= 8'd0;
            addr_q <= '0;
        end else begin
            flag_q <= flag_d;
            cnt_q  <= cnt_d;
            addr_q <= addr_d;
        end
    end

    assign err_flag_o = flag_q;
    assign err_cnt_o  = cnt_q;
    assign err_addr_o = addr_q;
endmodule

// File: rtl/mmio_ctrl_gen.sv
// FPro-style MMIO controller: decodes bus accesses into one-hot slot strobes,
// muxes slot read data back and logs illegal accesses.
module mmio_ctrl_gen
    import mmio_gen_pkg::*;
#(
    parameter int                        SLOT_BITS = 6,
    parameter int                        REG_BITS  = 5,
    parameter logic [(2**SLOT_BITS)-1:0] SLOT_MAP  = '1,
    parameter bit                        REG_RD    = 1'b1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               mmio_cs,
    input  logic                               mmio_wr,
    input  logic                               mmio_rd,
    input  logic [ADDR_W-1:0]                  mmio_addr,
    input  logic [DATA_W-1:0]                  mmio_wr_data,
    output logic [DATA_W-1:0]                  mmio_rd_data,
    output logic                               mmio_rd_valid,
    output logic [(2**SLOT_BITS)-1:0]          slot_cs,
    output logic [(2**SLOT_BITS)-1:0]          slot_mem_rd,
    output logic [(2**SLOT_BITS)-1:0]          slot_mem_wr,
    output logic [REG_BITS-1:0]                slot_reg_addr,
    output logic [DATA_W-1:0]                  slot_wr_data,
    input  logic [(2**SLOT_BITS)*DATA_W-1:0]   slot_rd_data,
    input  logic                               err_clr,
    output logic                               err_flag,
    output logic [7:0]                         err_cnt,
    output logic [ADDR_W-1:0]                  err_addr
);
    localparam int N_SLOT   = 2**SLOT_BITS;
    localparam int DEC_BITS = REG_BITS + SLOT_BITS;

    logic [SLOT_BITS-1:0] slot;
    logic [ADDR_W-1:0]    upper_bits;
    logic [N_SLOT-1:0]    slot_onehot;
    logic                 access, collide, range_bad, mapped, legal, rd_txn;
    logic [DATA_W-1:0]    sel_data, rd_now;
    err_cause_e           cause;

    assign slot          = mmio_addr[DEC_BITS-1:REG_BITS];
    assign slot_reg_addr = mmio_addr[REG_BITS-1:0];
    assign slot_wr_data  = mmio_wr_data;
    assign upper_bits    = mmio_addr >> DEC_BITS;

    assign access    = mmio_cs & (mmio_rd ^ mmio_wr);
    assign collide   = mmio_cs & mmio_rd & mmio_wr;
    assign range_bad = |upper_bits;
    assign mapped    = SLOT_MAP[slot];

    always_comb begin
        cause = ERR_NONE;
        if (collide) begin
            cause = ERR_RDWR;
        end else if (access && range_bad) begin
            cause = ERR_RANGE;
        end else if (access && !mapped) begin
            cause = ERR_UNMAPPED;
        end
    end

    assign legal       = access & (cause == ERR_NONE);
    assign slot_onehot = {{(N_SLOT-1){1'b0}}, 1'b1} << slot;
    assign slot_cs     = legal ? slot_onehot : '0;
    assign slot_mem_rd = mmio_rd ? slot_cs : '0;
    assign slot_mem_wr = mmio_wr ? slot_cs : '0;

    // A collision is not an access, so only a clean rd strobe starts a read;
    // unmapped or out-of-range reads still complete, returning zero.
    assign rd_txn   = access & mmio_rd;
    assign sel_data = slot_rd_data[DATA_W*int'(slot) +: DATA_W];
    assign rd_now   = legal ? sel_data : '0;

    if (REG_RD) begin : g_rd_reg
        logic [DATA_W-1:0] rd_data_q, rd_data_d;
        logic              rd_valid_q;

        assign rd_data_d = rd_txn ? rd_now : rd_data_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_data_q  <= rd_data_d;
                rd_valid_q <= rd_txn;
            end
        end

        assign mmio_rd_data  = rd_data_q;
        assign mmio_rd_valid = rd_valid_q;
    end else begin : g_rd_comb
        assign mmio_rd_data  = rd_txn ? rd_now : '0;
        assign mmio_rd_valid = rd_txn;
    end

    mmio_err_log u_err_log (
        .clk        (clk),
        .reset      (reset),
        .err_clr_i  (err_clr),
        .err_evt_i  (cause != ERR_NONE),
        .addr_i     (mmio_addr),
        .err_flag_o (err_flag),
        .err_cnt_o  (err_cnt),
        .err_addr_o (err_addr)
    );
endmodule

// File: doc/mmio_ctrl_gen.md
MMIO_CTRL_GEN -- requirements
Module: mmio_ctrl_gen

Interface
REQ-001 SHALL have parameter SLOT_BITS, default 6, meaning number of slot-select address bits (N_SLOT = 2**SLOT_BITS).
REQ-002 SHALL have parameter REG_BITS, default 5, meaning per-slot register address bits.
REQ-003 SHALL have parameter SLOT_MAP, default all-ones (N_SLOT bits), meaning mask of populated slots.
REQ-004 SHALL have parameter REG_RD, default 1, meaning 1 = registered read data, 0 = combinational read data.
REQ-005 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous active-high reset.
REQ-007 SHALL have ports mmio_cs, mmio_wr, mmio_rd  input  1 each  FPro bus select and strobes.
REQ-008 SHALL have port mmio_addr  input  21  bus word address.
REQ-009 SHALL have ports mmio_wr_data  input  32 and mmio_rd_data  output  32, bus data.
REQ-010 SHALL have port mmio_rd_valid  output  1  read data valid pulse.
REQ-011 SHALL have ports slot_cs, slot_mem_rd, slot_mem_wr  output  N_SLOT each  one-hot slot strobes.
REQ-012 SHALL have ports slot_reg_addr  output  REG_BITS and slot_wr_data  output  32, broadcast to all slots.
REQ-013 SHALL have port slot_rd_data  input  N_SLOT*32  flattened slot read data, slot k at bits [32k+31:32k].
REQ-014 SHALL have ports err_clr  input  1, err_flag  output  1, err_cnt  output  8, err_addr  output  21, forming the error log.

Function
REQ-015 SHALL define access = mmio_cs & (mmio_rd ^ mmio_wr); slot index = mmio_addr[REG_BITS+SLOT_BITS-1:REG_BITS]; slot_reg_addr = mmio_addr[REG_BITS-1:0].
REQ-016 SHALL assert slot_cs[k] (plus slot_mem_rd[k] or slot_mem_wr[k]) combinationally, same cycle, only when access, slot==k, SLOT_MAP[k]=1 and mmio_addr bits above REG_BITS+SLOT_BITS are zero; otherwise all strobes 0.
REQ-017 SHALL drive slot_wr_data = mmio_wr_data unconditionally.
REQ-018 SHALL, with REG_RD=0, drive mmio_rd_data = selected slot_rd_data and mmio_rd_valid = 1 in the same cycle as a legal read.
REQ-019 SHALL, with REG_RD=1, register the slot index on a legal read and present that slot's slot_rd_data, sampled at the read edge, on mmio_rd_data with mmio_rd_valid = 1 exactly one cycle later; data holds until the next read completes.
REQ-020 SHALL treat as an error: cs with rd and wr both high; access to a slot with SLOT_MAP bit 0; nonzero upper address bits. Error accesses produce no slot strobes.
REQ-021 SHALL complete an erroneous read with mmio_rd_data = 32'h0 and mmio_rd_valid asserted at normal latency.
REQ-022 SHALL, on error, set err_flag sticky, increment err_cnt saturating at 8'hFF, and capture mmio_addr into err_addr only when err_flag was 0 (first error kept).
REQ-023 SHALL, on err_clr without concurrent error, zero err_flag, err_cnt, err_addr the next cycle; on err_clr with a concurrent error, clear wins, then the error is logged: err_flag=1, err_cnt=1, err_addr=current mmio_addr.
REQ-024 SHALL allow back-to-back accesses every cycle, with no stall.

Reset
REQ-025 SHALL, on reset, zero mmio_rd_data, mmio_rd_valid, err_flag, err_cnt, err_addr and the captured slot index; reset has priority over bus activity and err_clr.
REQ-026 SHALL drop a read pending at reset (REG_RD=1), with no mmio_rd_valid after reset.

Structure
REQ-027 SHALL place the bus data width (32), address width (21) and error-cause enum (NONE, RDWR, UNMAPPED, RANGE) in package mmio_gen_pkg.
REQ-028 SHALL implement the error log (REQ-022..023) as sub-module mmio_err_log; decode and read mux stay in mmio_ctrl_gen.

Verification
REQ-029 SHALL verify: write addr 0x00043 with data 0x1234_5678 -> slot_mem_wr[2]=1, slot_reg_addr=3, slot_wr_data=0x1234_5678, no error.
REQ-030 SHALL verify with REG_RD=1: read slot 3, reg 0, slot 3 data 0xA5A5_0001 -> next cycle mmio_rd_data=0xA5A5_0001, mmio_rd_valid=1; back-to-back reads of slots 3 then 4 return in order.
REQ-031 SHALL verify with SLOT_MAP bit 5 = 0: read slot 5 -> no strobes, rd_data=0, err_flag=1, err_cnt=1, err_addr=0x000A0.
REQ-032 SHALL verify: 300 rd&wr-collision cycles -> err_cnt=0xFF, err_addr = first collision address.
REQ-033 SHALL verify: err_clr together with an access to addr 0x10000 -> err_cnt=1, err_addr=0x10000.
REQ-034 SHALL verify: reset asserted the cycle after a read -> mmio_rd_valid=0, all error outputs 0.
